// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared encodings, FSM states, flag indices and decode helpers
// for the multi-cycle CR16-style ALU datapath.
package seq_alu_pkg;

    localparam logic [3:0] OPC_REG = 4'b0000;
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;
    localparam logic [3:0] EXT_MOV = 4'b1101;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_ILL} op_e;

    // Immediate forms reuse the register-form extension code as their opcode.
    function automatic op_e decode_op(input logic [3:0] opcode, input logic [3:0] opext);
        logic [3:0] code;
        code = (opcode == OPC_REG) ? opext : opcode;
        case (code)
            EXT_ADD: decode_op = OP_ADD;
            EXT_SUB: decode_op = OP_SUB;
            EXT_CMP: decode_op = OP_CMP;
            EXT_AND: decode_op = OP_AND;
            EXT_OR:  decode_op = OP_OR;
            EXT_XOR: decode_op = OP_XOR;
            EXT_MOV: decode_op = OP_MOV;
            default: decode_op = OP_ILL;
        endcase
    endfunction

    function automatic logic sext_imm(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_CMP, OP_MOV};
    endfunction

endpackage

// File: rtl/seq_alu_regfile.sv
// seq_alu_regfile: register file with two combinational read ports, a debug
// read port and one synchronous write port.
module seq_alu_regfile #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REGBITS-1:0] ra_addr,
    input  logic [REGBITS-1:0] rb_addr,
    input  logic [REGBITS-1:0] dbg_addr,
    output logic [WIDTH-1:0]   ra_data,
    output logic [WIDTH-1:0]   rb_data,
    output logic [WIDTH-1:0]   dbg_data,
    input  logic               we,
    input  logic [REGBITS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata
);

    logic [WIDTH-1:0] mem_q [2**REGBITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REGBITS; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data  = mem_q[ra_addr];
    assign rb_data  = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/seq_alu_datapath.sv
// seq_alu_datapath: multi-cycle ALU datapath (IDLE/READ/EXEC/WB) with an
// internal register file and PSR flags {N,Z,F,L,C}.
module seq_alu_datapath
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int IMMBITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [3:0]         opext,
    input  logic [REGBITS-1:0] rdest,
    input  logic [REGBITS-1:0] rsrc,
    input  logic [IMMBITS-1:0] imm,
    output logic               done,
    output logic               err,
    output logic               wb_en,
    output logic [REGBITS-1:0] wb_addr,
    output logic [WIDTH-1:0]   wb_data,
    output logic [4:0]         flags,
    input  logic [REGBITS-1:0] dbg_addr,
    output logic [WIDTH-1:0]   dbg_data
);

    state_e             state_q, state_d;
    op_e                op_q;
    logic               imm_form_q;
    logic [REGBITS-1:0] rd_q, rs_q;
    logic [IMMBITS-1:0] imm_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, rf_a, rf_b, imm_ext;
    logic [4:0]         flags_q, nflags_q, nflags_d;
    logic [WIDTH:0]     sum, diff;
    logic               accept;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_WB);
    assign accept   = in_valid && in_ready;
    assign done     = state_q == S_WB;
    assign err      = done && (op_q == OP_ILL);
    assign wb_en    = done && !(op_q inside {OP_CMP, OP_ILL});
    assign wb_addr  = wb_en ? rd_q : '0;
    assign wb_data  = wb_en ? res_q : '0;
    assign flags    = flags_q;
    assign imm_ext  = sext_imm(op_q) ? {{(WIDTH-IMMBITS){imm_q[IMMBITS-1]}}, imm_q}
                                     : {{(WIDTH-IMMBITS){1'b0}}, imm_q};

    // An accept in WB chains straight into READ; the write lands on the same
    // edge, so the next READ sees the fresh value without any bypass.
    always_comb begin
        state_d = (state_q == S_IDLE) ? (accept ? S_READ : S_IDLE) :
                  (state_q == S_READ) ? S_EXEC :
                  (state_q == S_EXEC) ? S_WB :
                  (accept ? S_READ : S_IDLE);
    end

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        res_d    = b_q;
        nflags_d = flags_q;
        case (op_q)
            OP_ADD: begin
                res_d            = sum[WIDTH-1:0];
                nflags_d[FLAG_C] = sum[WIDTH];
                nflags_d[FLAG_F] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d            = diff[WIDTH-1:0];
                nflags_d[FLAG_C] = diff[WIDTH];
                nflags_d[FLAG_F] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_CMP: begin
                nflags_d[FLAG_Z] = a_q == b_q;
                nflags_d[FLAG_L] = diff[WIDTH];
                nflags_d[FLAG_N] = $signed(a_q) < $signed(b_q);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_XOR:  res_d = a_q ^ b_q;
            default: res_d = b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            imm_form_q <= 1'b0;
            rd_q       <= '0;
            rs_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            nflags_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= decode_op(opcode, opext);
                imm_form_q <= opcode != OPC_REG;
                rd_q       <= rdest;
                rs_q       <= rsrc;
                imm_q      <= imm;
            end
            if (state_q == S_READ) begin
                a_q <= rf_a;
                b_q <= imm_form_q ? imm_ext : rf_b;
            end
            if (state_q == S_EXEC) begin
                res_q    <= res_d;
                nflags_q <= nflags_d;
            end
            if (state_q == S_WB) flags_q <= nflags_q;
        end
    end

    seq_alu_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rd_q),
        .rb_addr  (rs_q),
        .dbg_addr (dbg_addr),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .waddr    (rd_q),
        .wdata    (res_q)
    );

endmodule

// File: tb/tb_seq_alu_datapath.sv
// tb_seq_alu_datapath: directed and randomized checks of seq_alu_datapath
// against an integer-arithmetic reference model.
module tb_seq_alu_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0, opext = '0, rdest = '0, rsrc = '0, dbg_addr = '0;
    logic [7:0]  imm = '0;
    logic        done, err, wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data, dbg_data;
    logic [4:0]  flags;

    int          passed = 0, total = 0;
    int          m_reg [16];
    logic [4:0]  m_flags = '0;
    logic [15:0] p_res;
    logic [4:0]  p_nf;
    logic [3:0]  p_rd;
    bit          p_wr, p_ill;

    always #5 clk = ~clk;

    seq_alu_datapath dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .opext(opext), .rdest(rdest), .rsrc(rsrc), .imm(imm),
        .done(done), .err(err), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic check_all();
        for (int i = 0; i < 16; i++) rd_chk("reg", 4'(i), 16'(m_reg[i]));
    endtask

    // Reference semantics with plain integers: values held as 0..65535.
    task automatic predict(input logic [3:0] opc, ext, rd, rs, input logic [7:0] im);
        int  cls, a, b, sa, sb, s;
        cls = (opc == 0) ? int'(ext) : int'(opc);
        a = m_reg[rd];
        if (opc != 0) b = (cls inside {5, 9, 11, 13} && im >= 128) ? int'(im) + 65280 : int'(im);
        else b = m_reg[rs];
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        p_nf = m_flags; p_wr = 1; p_ill = 0; p_res = '0; p_rd = rd;
        case (cls)
            5: begin
                s = a + b; p_res = 16'(s % 65536);
                p_nf[0] = s > 65535;
                p_nf[2] = (sa + sb > 32767) || (sa + sb < -32768);
            end
            9: begin
                p_res = 16'((a - b + 65536) % 65536);
                p_nf[0] = a < b;
                p_nf[2] = (sa - sb > 32767) || (sa - sb < -32768);
            end
            11: begin
                p_wr = 0;
                p_nf[3] = a == b; p_nf[1] = a < b; p_nf[4] = sa < sb;
            end
            1:  p_res = 16'(a & b);
            2:  p_res = 16'(a | b);
            3:  p_res = 16'(a ^ b);
            13: p_res = 16'(b);
            default: begin p_wr = 0; p_ill = 1; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the READ cycle.
    task automatic start(input logic [3:0] opc, ext, rd, rs, input logic [7:0] im);
        chk("in_ready", 32'(in_ready), 1);
        opcode = opc; opext = ext; rdest = rd; rsrc = rs; imm = im; in_valid = 1'b1;
        predict(opc, ext, rd, rs, im);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); opext = 4'($urandom); rdest = 4'($urandom);
        rsrc = 4'($urandom); imm = 8'($urandom);
        @(negedge clk);
    endtask

    // Returns at the negedge of the WB cycle, with the model updated.
    task automatic retire();
        chk("done_c1", 32'(done), 0); chk("wb_en_c1", 32'(wb_en), 0);
        @(negedge clk);
        chk("done_c2", 32'(done), 0); chk("wb_en_c2", 32'(wb_en), 0);
        @(negedge clk);
        chk("done_c3", 32'(done), 1);
        chk("err", 32'(err), 32'(p_ill));
        chk("wb_en", 32'(wb_en), 32'(p_wr));
        if (p_wr) begin
            chk("wb_addr", 32'(wb_addr), 32'(p_rd));
            chk("wb_data", 32'(wb_data), 32'(p_res));
            m_reg[p_rd] = int'(p_res);
        end
        m_flags = p_nf;
    endtask

    task automatic settle();
        @(negedge clk);
        chk("flags", 32'(flags), 32'(m_flags));
        chk("done_after", 32'(done), 0);
        rd_chk("dbg_rd", p_rd, 16'(m_reg[p_rd]));
    endtask

    task automatic op(input logic [3:0] opc, ext, rd, rs, input logic [7:0] im);
        start(opc, ext, rd, rs, im);
        retire();
        settle();
    endtask

    task automatic pick(output logic [3:0] opc, ext);
        logic [3:0] legal [7];
        int k;
        legal = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
        k = $urandom_range(0, 15);
        if (k < 7) begin opc = 4'h0; ext = legal[k]; end
        else if (k < 14) begin opc = legal[k-7]; ext = 4'($urandom); end
        else begin opc = 4'($urandom); ext = 4'($urandom); end
    endtask

    initial begin
        logic [3:0] o, e;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_flags", 32'(flags), 0);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        op(4'hD, 0, 1, 0, 8'h7F);  rd_chk("movi_r1", 1, 16'h007F);
        op(4'hD, 0, 2, 0, 8'h80);  rd_chk("movi_r2", 2, 16'hFF80);

        op(4'hD, 0, 8, 0, 8'h80);
        for (int i = 0; i < 8; i++) op(4'h0, 4'h5, 8, 8, 8'h00);
        rd_chk("dbl_r8", 8, 16'h8000);
        op(4'hD, 0, 1, 0, 8'hFF);
        op(4'h0, 4'h3, 1, 8, 8'h00); rd_chk("xor_r1", 1, 16'h7FFF);
        op(4'hD, 0, 2, 0, 8'h01);
        op(4'h0, 4'h5, 1, 2, 8'h00);
        rd_chk("add_ovf", 1, 16'h8000);
        chk("add_F", 32'(flags[2]), 1);
        chk("add_C", 32'(flags[0]), 0);
        op(4'hD, 0, 3, 0, 8'hFF);
        op(4'h5, 0, 3, 0, 8'h01);
        rd_chk("addi_wrap", 3, 16'h0000);
        chk("addi_C", 32'(flags[0]), 1);

        op(4'hD, 0, 4, 0, 8'h05);
        op(4'hD, 0, 5, 0, 8'hFE);
        op(4'h0, 4'hB, 4, 5, 8'h00);
        chk("cmp_lt_flags", 32'(flags), 32'(5'b00011));
        rd_chk("cmp_r4", 4, 16'h0005);
        op(4'h0, 4'hB, 4, 4, 8'h00);
        chk("cmp_eq_flags", 32'(flags), 32'(5'b01001));
        op(4'h1, 0, 5, 0, 8'hF0);
        rd_chk("andi_r5", 5, 16'h00F0);
        chk("andi_flags", 32'(flags), 32'(5'b01001));

        op(4'hD, 0, 7, 0, 8'h10);
        start(4'h5, 0, 6, 0, 8'h03);
        retire();
        start(4'h0, 4'h5, 7, 6, 8'h00);
        retire();
        settle();
        rd_chk("b2b_r6", 6, 16'h0003);
        rd_chk("b2b_r7", 7, 16'h0013);

        op(4'h7, 0, 1, 2, 8'h55);
        check_all();

        start(4'h0, 4'h5, 1, 2, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done", 32'(done), 0);
        chk("abort_wb_en", 32'(wb_en), 0);
        chk("abort_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("abort_done2", 32'(done), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_flags = '0;
        chk("abort_flags", 32'(flags), 0);
        check_all();

        for (int i = 0; i < 16; i++) op(4'hD, 0, 4'(i), 0, 8'($urandom));
        for (int n = 0; n < 60; n++) begin
            pick(o, e);
            start(o, e, 4'($urandom), 4'($urandom), 8'($urandom));
            retire();
            if ($urandom_range(0, 2) == 0) begin
                pick(o, e);
                start(o, e, 4'($urandom), 4'($urandom), 8'($urandom));
                retire();
            end
            settle();
        end
        check_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
